// File: rtl/bus_rx_buffer_if.sv
// Receive-side bus bundle: ECC-tagged words from upstream and the
// first-word-fall-through handshake toward the consumer.
interface bus_rx_buffer_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_err_detected;
    logic        in_err_corrected;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, in_err_detected, in_err_corrected, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_err_detected, in_err_corrected, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/bus_rx_buffer.sv
// Receive FIFO behind an ECC-checked bus: discards uncorrectable words, buffers
// the rest first-word-fall-through, and keeps saturating error/drop statistics.
module bus_rx_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bus_rx_buffer_if.slave           bus,
    input  logic                     clr_stats,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         corr_count,
    output logic [CNT_W-1:0]         uncorr_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);
    localparam logic [CNT_W-1:0] SAT  = {CNT_W{1'b1}};

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic is_uncorr, is_good, pop, push_ok, push, drop;

    always_comb begin
        is_uncorr = bus.in_valid & bus.in_err_detected & ~bus.in_err_corrected;
        is_good   = bus.in_valid & ~is_uncorr;
        pop       = (count != '0) & bus.out_ready;
        // A full FIFO still takes a word when the head leaves in the same cycle.
        push_ok   = (count < FULL) | pop;
        push      = is_good & push_ok;
        drop      = is_good & ~push_ok;
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign fifo_count    = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // Pointers are AW bits wide so the power-of-two wrap is implicit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count   <= '0;
            uncorr_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else if (clr_stats) begin
            corr_count   <= '0;
            uncorr_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push && bus.in_err_corrected && corr_count != SAT)
                corr_count <= corr_count + CNT_W'(1);
            if (is_uncorr && uncorr_count != SAT)
                uncorr_count <= uncorr_count + CNT_W'(1);
            if (drop && drop_count != SAT)
                drop_count <= drop_count + CNT_W'(1);
            if (drop)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_rx_buffer.sv
// Checks bus_rx_buffer against a queue-based model every cycle, with directed
// scenarios pinned by literal values followed by a randomized soak.
module tb_bus_rx_buffer;
    localparam int DEPTH = 8;
    localparam int T_CNT_W = 4;
    localparam int SAT = (1 << T_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_stats = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [T_CNT_W-1:0] corr_count, uncorr_count, drop_count;
    logic overflow;

    bus_rx_buffer_if bus ();

    bus_rx_buffer #(.DEPTH(DEPTH), .CNT_W(T_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_stats(clr_stats),
        .fifo_count(fifo_count), .corr_count(corr_count),
        .uncorr_count(uncorr_count), .drop_count(drop_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [$];
    int m_corr, m_uncorr, m_drop;
    bit m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_corr = 0; m_uncorr = 0; m_drop = 0; m_ovf = 0;
    endtask

    // Applies the classification and FIFO rules to the inputs seen at this edge.
    task automatic model_step();
        bit pop, uncorr, good, can;
        if (!rst_n) begin
            model_clear();
            return;
        end
        pop    = (mq.size() != 0) && bus.out_ready;
        uncorr = bus.in_valid && bus.in_err_detected && !bus.in_err_corrected;
        good   = bus.in_valid && !uncorr;
        can    = (mq.size() < DEPTH) || pop;
        if (pop) void'(mq.pop_front());
        if (good && can) mq.push_back(bus.in_data);
        if (clr_stats) begin
            m_corr = 0; m_uncorr = 0; m_drop = 0; m_ovf = 0;
        end else begin
            if (uncorr && m_uncorr < SAT) m_uncorr++;
            if (good && can && bus.in_err_corrected && m_corr < SAT) m_corr++;
            if (good && !can) begin
                if (m_drop < SAT) m_drop++;
                m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", bus.out_valid, mq.size() != 0);
        chk("fifo_count", fifo_count, mq.size());
        chk("corr_count", corr_count, m_corr);
        chk("uncorr_count", uncorr_count, m_uncorr);
        chk("drop_count", drop_count, m_drop);
        chk("overflow", overflow, m_ovf);
        if (mq.size() != 0) chk("out_data", bus.out_data, mq[0]);
    endtask

    // One clock: model sees the edge's inputs, outputs compared at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit det, input bit cor);
        bus.in_valid = v;
        bus.in_data = d;
        bus.in_err_detected = det;
        bus.in_err_corrected = cor;
    endtask

    initial begin
        model_clear();
        drive(0, 32'h0, 0, 0);
        bus.out_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_counters", {corr_count, uncorr_count, drop_count, overflow}, 0);
        rst_n = 1'b1;

        // Single clean word falls through on the next cycle.
        drive(1, 32'hA5A5A5A5, 0, 0);
        cyc();
        chk("lit_first_valid", bus.out_valid, 1);
        chk("lit_first_data", bus.out_data, 32'hA5A5A5A5);
        chk("lit_first_count", fifo_count, 1);
        chk("lit_first_stats", {corr_count, uncorr_count, drop_count, overflow}, 0);

        drive(1, 32'hFFFFFFFF, 1, 1);
        cyc();
        chk("lit_corr_count", corr_count, 1);
        chk("lit_corr_uncorr", uncorr_count, 0);
        chk("lit_corr_fifo", fifo_count, 2);

        drive(1, 32'h98765432, 1, 0);
        cyc();
        chk("lit_uncorr_fifo", fifo_count, 2);
        chk("lit_uncorr_count", uncorr_count, 1);
        chk("lit_uncorr_head", bus.out_data, 32'hA5A5A5A5);

        drive(0, 0, 0, 0);
        bus.out_ready = 1'b1;
        cyc();
        chk("lit_second_head", bus.out_data, 32'hFFFFFFFF);
        cyc();
        chk("lit_drained", bus.out_valid, 0);
        clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;

        // Overfill with DEPTH+2 words, then drain in order.
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1, 32'(i), 0, 0);
            cyc();
        end
        drive(0, 0, 0, 0);
        chk("lit_full_count", fifo_count, 8);
        chk("lit_full_drop", drop_count, 2);
        chk("lit_full_ovf", overflow, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("lit_drain_order", bus.out_data, 32'(i));
            cyc();
        end
        chk("lit_drain_empty", bus.out_valid, 0);
        clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;

        // Fill, then push and pop together across several pointer wraps.
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'(100 + i), 0, 0);
            cyc();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("lit_wrap_head", bus.out_data, (k < DEPTH) ? 32'(100 + k) : 32'(200 + k - DEPTH));
            drive(1, 32'(200 + k), 0, 0);
            cyc();
            chk("lit_wrap_count", fifo_count, 8);
            chk("lit_wrap_drop", drop_count, 0);
        end

        // Force overflow, then clear in the same cycle as an uncorrectable word.
        bus.out_ready = 1'b0;
        drive(1, 32'h1234, 0, 0);
        cyc();
        chk("lit_ovf_set", overflow, 1);
        drive(1, 32'hDEAD, 1, 0);
        clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;
        chk("lit_clr_uncorr", uncorr_count, 0);
        chk("lit_clr_ovf", overflow, 0);
        chk("lit_clr_fifo", fifo_count, 8);

        drive(0, 0, 0, 0);
        bus.out_ready = 1'b1;
        repeat (5) cyc();
        chk("lit_three_left", fifo_count, 3);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("lit_async_valid", bus.out_valid, 0);
        chk("lit_async_count", fifo_count, 0);
        model_clear();
        cyc();
        rst_n = 1'b1;
        drive(1, 32'hCAFE0001, 0, 0);
        cyc();
        chk("lit_post_rst_data", bus.out_data, 32'hCAFE0001);
        chk("lit_post_rst_count", fifo_count, 1);

        // Randomized soak with occasional clears and resets.
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
            bus.out_ready = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 3) == 0);
            clr_stats = ($urandom_range(0, 299) == 0);
            rst_n = ($urandom_range(0, 799) != 0);
            cyc();
        end
        rst_n = 1'b1;
        clr_stats = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
